// File: rtl/io_write_capture.sv
// io_write_capture
//   Passive snooper for the CPU I/O bus. Every qualifying port write is logged
//   into a show-ahead FIFO as {seq, ts, addr, data}. Consumers drain it with a
//   valid/ready handshake. Writes that arrive while the FIFO is full are counted
//   and flagged. A watchdog raises a sticky timeout after a run of idle cycles.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   io_data/addr/we     snooped CPU I/O bus (io_we pulses once per write)
//   enable              gates capture, timestamp counting and the watchdog
//   clear               synchronous clear, same effect as reset
//   port_mask           bit i = 1 captures writes to port i
//   wdog_limit          idle cycles before timeout; 0 disables the watchdog
//   out_valid/out_ready head-of-FIFO handshake
//   out_data/addr/ts/seq head entry fields, forced to 0 while out_valid = 0
//   level               FIFO occupancy
//   overflow            sticky, set when an entry is dropped
//   drop_count          dropped entries, saturating at 255
//   timeout             sticky watchdog expiry
module io_write_capture #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16,
    parameter int TS_W   = 16,
    parameter int SEQ_W  = 8,
    parameter int WDOG_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_W-1:0]        io_data,
    input  logic [ADDR_W-1:0]        io_addr,
    input  logic                     io_we,
    input  logic                     enable,
    input  logic                     clear,
    input  logic [(2**ADDR_W)-1:0]   port_mask,
    input  logic [WDOG_W-1:0]        wdog_limit,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [ADDR_W-1:0]        out_addr,
    output logic [TS_W-1:0]          out_ts,
    output logic [SEQ_W-1:0]         out_seq,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [7:0]               drop_count,
    output logic                     timeout
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int E_W   = SEQ_W + TS_W + ADDR_W + DATA_W;

    // Entry storage; contents need no reset because the pointers qualify them.
    logic [E_W-1:0]    r_mem [DEPTH];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PTR_W:0]    r_wr_ptr;
    logic [PTR_W:0]    r_rd_ptr;

    logic [TS_W-1:0]   r_ts;
    logic [SEQ_W-1:0]  r_seq;
    logic [WDOG_W-1:0] r_idle;
    logic              r_overflow;
    logic [7:0]        r_drop;
    logic              r_timeout;

    logic              w_clr;
    logic              w_empty;
    logic              w_full;
    logic              w_qual;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic [E_W-1:0]    w_head;

    assign w_clr   = reset | clear;
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);

    assign w_qual  = enable & io_we & port_mask[io_addr];
    assign w_pop   = ~w_empty & out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push  = w_qual & (~w_full | w_pop);
    assign w_drop  = w_qual & w_full & ~w_pop;

    assign w_head  = r_mem[r_rd_ptr[PTR_W-1:0]];

    // Head presentation: outputs are zeroed whenever nothing is valid.
    always_comb begin
        out_valid = ~w_empty;
        out_seq   = '0;
        out_ts    = '0;
        out_addr  = '0;
        out_data  = '0;
        if (!w_empty) begin
            {out_seq, out_ts, out_addr, out_data} = w_head;
        end
    end

    assign level      = r_wr_ptr - r_rd_ptr;
    assign overflow   = r_overflow;
    assign drop_count = r_drop;
    assign timeout    = r_timeout;

    // Storage write. Gated by clear/reset so a write coinciding with them is lost.
    always_ff @(posedge clk) begin
        if (w_push && !w_clr) begin
            r_mem[r_wr_ptr[PTR_W-1:0]] <= {r_seq, r_ts, io_addr, io_data};
        end
    end

    // FIFO pointers.
    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
        end
    end

    // Timestamp and sequence counters. seq advances on dropped writes too,
    // so gaps in out_seq expose losses to the consumer.
    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_ts  <= '0;
            r_seq <= '0;
        end else begin
            if (enable) r_ts  <= r_ts + TS_W'(1);
            if (w_qual) r_seq <= r_seq + SEQ_W'(1);
        end
    end

    // Overflow accounting.
    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_overflow <= 1'b0;
            r_drop     <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
        end
    end

    // Idle watchdog. The counter saturates at the limit; timeout latches on
    // the edge after the counter has reached it.
    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_idle    <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (w_qual) begin
                r_idle <= '0;
            end else if (enable && (wdog_limit != '0) && (r_idle < wdog_limit)) begin
                r_idle <= r_idle + WDOG_W'(1);
            end
            if ((wdog_limit != '0) && (r_idle >= wdog_limit)) begin
                r_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: doc/io_write_capture.md
Name: io_write_capture

Overview:
- Passive snooper on the CPU I/O bus (io_addr/io_data/io_we) of the 8-bit computer.
- Logs every qualifying port write into a show-ahead FIFO as {seq, timestamp, addr, data}, with per-port enables, overflow accounting and an idle watchdog.
- Readout uses a valid/ready handshake.
- Replaces bench-side io_we polling; usable in simulation and on FPGA as a debug tap.

Parameters:
- DATA_W, 8, I/O data width
- ADDR_W, 4, I/O port address width; 2**ADDR_W capturable ports
- DEPTH, 16, FIFO entries; power of two, >= 2
- TS_W, 16, timestamp counter width
- SEQ_W, 8, sequence counter width
- WDOG_W, 16, watchdog limit/counter width

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- io_data  input  DATA_W  I/O bus data (sampled only when io_we=1)
- io_addr  input  ADDR_W  I/O bus port address
- io_we  input  1  CPU I/O write strobe, one cycle per write
- enable  input  1  capture/timestamp/watchdog enable
- clear  input  1  synchronous clear of FIFO, counters and flags
- port_mask  input  2**ADDR_W  bit i=1 captures writes to port i
- wdog_limit  input  WDOG_W  idle cycles before timeout; 0 disables
- out_valid  output  1  FIFO head entry valid
- out_ready  input  1  consumer accepts head entry
- out_data  output  DATA_W  head entry data
- out_addr  output  ADDR_W  head entry port address
- out_ts  output  TS_W  head entry timestamp
- out_seq  output  SEQ_W  head entry sequence number
- level  output  $clog2(DEPTH)+1  current FIFO occupancy
- overflow  output  1  sticky: an entry was dropped
- drop_count  output  8  dropped entries, saturates at 255
- timeout  output  1  sticky watchdog expiry

Behaviour:
- Reset values: out_valid=0, out_data/out_addr/out_ts/out_seq=0, level=0, overflow=0, drop_count=0, timeout=0. Internal ts, seq and idle counters are 0; FIFO is empty.
- Reset applies only on a clk edge with reset=1, takes priority over everything, and aborts any pending push or pop.
- clear (when reset=0) has the same effect as reset. A write coinciding with clear is not captured.
- ts counter increments by 1 each cycle that enable=1 and wraps modulo 2**TS_W. It holds when enable=0.
- Qualifying write: enable=1, io_we=1, port_mask[io_addr]=1.
- Push: a qualifying write stores {seq, ts (pre-increment value of that cycle), io_addr, io_data}.
- seq increments on every qualifying write, including dropped ones, and wraps modulo 2**SEQ_W. A gap in out_seq therefore reveals drops.
- Latency: an entry written into an empty FIFO appears on out_valid/out_* on the next cycle.
- Pop occurs when out_valid=1 and out_ready=1 at the clock edge. The next entry, if any, is presented on the following cycle.
- out_* are 0 whenever out_valid=0.
- level updates one cycle after a push or pop. A simultaneous push and pop leaves level unchanged.
- Full with simultaneous pop: the push succeeds and nothing is dropped.
- Full without pop: the entry is discarded, overflow sets to 1, and drop_count increments (holds at 255).
- Empty with out_ready=1: no effect.
- Watchdog: when enable=1 and wdog_limit!=0, the idle counter increments each cycle. It resets to 0 on any qualifying write.
- The cycle the idle counter reaches wdog_limit, timeout sets to 1 on the next edge and stays set until reset/clear. The idle counter saturates.
- enable=0 freezes the idle counter.
- A write to an unmasked port is ignored entirely: no push, no seq increment, no watchdog kick.
- FIFO pointers are $clog2(DEPTH) bits plus a wrap bit; full/empty are derived from pointer compare. Storage is a register array.

Test Plan:
- Reset, enable=1, mask=16'h0001. Writes 0x00,0x01,0x01,0x02 to port 0 on cycles 5,9,13,17; out_ready=1 → four entries, seq 0..3, ts 5,9,13,17, data as written, each out_valid one cycle after its write.
- mask=16'h0001 → a write of 0xAA to port 3 produces no entry, seq unchanged, and the watchdog is not kicked.
- DEPTH=16, out_ready=0, 20 qualifying writes → level=16, overflow=1, drop_count=4. Draining yields seq 0..15; the next capture has seq 20.
- FIFO full, push and pop in the same cycle → level stays 16, overflow stays 0, and the new entry appears last.
- wdog_limit=50, no writes for 50 cycles → timeout=1 on the following cycle. With wdog_limit=0 over 1000 idle cycles → timeout stays 0.
- Assert clear in the same cycle as a write, with 5 entries queued and flags set → next cycle: level=0, out_valid=0, overflow=0, timeout=0, the write is not captured, and the next capture has seq 0, ts 0.
